// File: rtl/pfm_pred_filter.sv
// pfm_pred_filter
//   Core-side consumer of the prefetch monitor's prediction channel. Incoming
//   predicted byte addresses are reduced to cache-line tags and compared
//   against a small fully associative filter of recently issued lines. Hits
//   are consumed and dropped. Misses are queued in a FIFO, recorded in the
//   filter with round-robin replacement, and issued to the L1 prefetch port
//   as line-aligned addresses.
//
// Optional feature macro: PFM_PRED_FILTER_STATS_EN
//   When defined, the block exports saturating 16-bit event counters
//   (stat_drop, stat_issue, stat_stall). When undefined, those ports and
//   counters are absent.
//
// Ports:
//   clk         clock
//   reset       synchronous active-high reset
//   pred_addr   predicted byte address (ignored while pred_valid=0)
//   pred_valid  prediction valid
//   pred_retry  high while the FIFO is full; the sender holds its request
//   pf_addr     line-aligned prefetch address (FIFO head, 0 when empty)
//   pf_valid    prefetch request valid (FIFO not empty)
//   pf_retry    high when L1 cannot accept; pf_addr/pf_valid hold
//   flush       invalidates every filter entry and rewinds replacement pointer
//   stat_drop   (optional) filter-hit drop count
//   stat_issue  (optional) completed prefetch transfer count
//   stat_stall  (optional) cycles with pred_valid && pred_retry
module pfm_pred_filter #(
  parameter int AddrBits    = 48,
  parameter int LineBits    = 6,
  parameter int FiltEntries = 8,
  parameter int FifoDepth   = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [AddrBits-1:0] pred_addr,
  input  logic                pred_valid,
  output logic                pred_retry,
  output logic [AddrBits-1:0] pf_addr,
  output logic                pf_valid,
  input  logic                pf_retry,
  input  logic                flush
`ifdef PFM_PRED_FILTER_STATS_EN
  ,
  output logic [15:0]         stat_drop,
  output logic [15:0]         stat_issue,
  output logic [15:0]         stat_stall
`endif
);

  localparam int TagW     = AddrBits - LineBits;
  localparam int FiltPtrW = $clog2(FiltEntries);
  localparam int FifoPtrW = $clog2(FifoDepth);
  localparam int CountW   = FifoPtrW + 1;

  // Filter state
  logic [TagW-1:0]        filt_tag_reg [FiltEntries];
  logic [FiltEntries-1:0] filt_valid_reg, filt_valid_next;
  logic [FiltPtrW-1:0]    filt_ptr_reg, filt_ptr_next;
  logic [FiltPtrW-1:0]    filt_wr_idx;
  logic [FiltEntries-1:0] hit_vec;

  // FIFO state (tags only; the line offset is always zero)
  logic [TagW-1:0]        fifo_mem [FifoDepth];
  logic [FifoPtrW-1:0]    rd_ptr_reg, wr_ptr_reg;
  logic [CountW-1:0]      count_reg, count_next;

  logic [TagW-1:0]        pred_tag;
  logic                   filt_hit;
  logic                   fifo_full;
  logic                   fifo_empty;
  logic                   pred_accept;
  logic                   enq;
  logic                   deq;

  // Byte offset within the line carries no information for a line prefetch.
  logic                   unused_line_offset;
  assign unused_line_offset = ^pred_addr[LineBits-1:0];

  assign pred_tag = pred_addr[AddrBits-1:LineBits];

  // Parallel tag compare across all filter entries.
  generate
    for (genvar gi = 0; gi < FiltEntries; gi++) begin : g_cmp
      assign hit_vec[gi] = filt_valid_reg[gi] && (filt_tag_reg[gi] == pred_tag);
    end
  endgenerate

  // A prediction arriving together with flush must not match entries that
  // are being invalidated on this same edge.
  assign filt_hit    = (|hit_vec) && !flush;

  assign fifo_full   = (count_reg == CountW'(FifoDepth));
  assign fifo_empty  = (count_reg == '0);

  // Retry looks at registered occupancy only: a full FIFO never accepts,
  // even if the head drains on the same edge.
  assign pred_retry  = fifo_full;
  assign pred_accept = pred_valid && !fifo_full;
  assign enq         = pred_accept && !filt_hit;
  assign deq         = !fifo_empty && !pf_retry;

  assign pf_valid    = !fifo_empty;
  assign pf_addr     = fifo_empty ? '0 : {fifo_mem[rd_ptr_reg], {LineBits{1'b0}}};

  // Filter next state: flush clears first, then a same-cycle miss lands in
  // entry 0 so it survives the flush.
  always_comb begin
    filt_valid_next = filt_valid_reg;
    filt_ptr_next   = filt_ptr_reg;
    filt_wr_idx     = filt_ptr_reg;
    if (flush) begin
      filt_valid_next = '0;
      filt_ptr_next   = '0;
      filt_wr_idx     = '0;
    end
    if (enq) begin
      filt_valid_next[filt_wr_idx] = 1'b1;
      filt_ptr_next                = filt_wr_idx + FiltPtrW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      filt_valid_reg <= '0;
      filt_ptr_reg   <= '0;
    end else begin
      filt_valid_reg <= filt_valid_next;
      filt_ptr_reg   <= filt_ptr_next;
    end
  end

  // Tag storage needs no reset; the valid bits qualify it.
  always_ff @(posedge clk) begin
    if (!reset && enq) begin
      filt_tag_reg[filt_wr_idx] <= pred_tag;
    end
  end

  // FIFO storage
  always_ff @(posedge clk) begin
    if (enq) begin
      fifo_mem[wr_ptr_reg] <= pred_tag;
    end
  end

  always_comb begin
    count_next = count_reg;
    case ({enq, deq})
      2'b10:   count_next = count_reg + CountW'(1);
      2'b01:   count_next = count_reg - CountW'(1);
      default: count_next = count_reg;
    endcase
  end

  // Depth is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (enq) begin
        wr_ptr_reg <= wr_ptr_reg + FifoPtrW'(1);
      end
      if (deq) begin
        rd_ptr_reg <= rd_ptr_reg + FifoPtrW'(1);
      end
      count_reg <= count_next;
    end
  end

`ifdef PFM_PRED_FILTER_STATS_EN
  logic [15:0] stat_drop_reg, stat_issue_reg, stat_stall_reg;
  logic        drop_evt, stall_evt;

  assign drop_evt  = pred_accept && filt_hit;
  assign stall_evt = pred_valid && fifo_full;

  // Saturating counters; flush leaves them alone.
  always_ff @(posedge clk) begin
    if (reset) begin
      stat_drop_reg  <= '0;
      stat_issue_reg <= '0;
      stat_stall_reg <= '0;
    end else begin
      if (drop_evt && (stat_drop_reg != 16'hFFFF)) begin
        stat_drop_reg <= stat_drop_reg + 16'd1;
      end
      if (deq && (stat_issue_reg != 16'hFFFF)) begin
        stat_issue_reg <= stat_issue_reg + 16'd1;
      end
      if (stall_evt && (stat_stall_reg != 16'hFFFF)) begin
        stat_stall_reg <= stat_stall_reg + 16'd1;
      end
    end
  end

  assign stat_drop  = stat_drop_reg;
  assign stat_issue = stat_issue_reg;
  assign stat_stall = stat_stall_reg;
`endif

endmodule

// File: tb/tb_pfm_pred_filter.sv
// Testbench for pfm_pred_filter. A reference model of the recent-line filter
// and the prefetch queue pushes expected prefetch addresses into a scoreboard
// queue when a prediction is accepted; the head is compared against pf_addr
// every cycle and popped when the DUT completes a prefetch transfer.
module tb_pfm_pred_filter;

  localparam int AddrBits    = 48;
  localparam int LineBits    = 6;
  localparam int FiltEntries = 8;
  localparam int FifoDepth   = 4;
  localparam int TagW        = AddrBits - LineBits;

  logic                clk = 1'b0;
  logic                reset;
  logic [AddrBits-1:0] pred_addr;
  logic                pred_valid;
  logic                pred_retry;
  logic [AddrBits-1:0] pf_addr;
  logic                pf_valid;
  logic                pf_retry;
  logic                flush;
`ifdef PFM_PRED_FILTER_STATS_EN
  logic [15:0]         stat_drop, stat_issue, stat_stall;
`endif

  always #5 clk = ~clk;

  pfm_pred_filter #(
    .AddrBits(AddrBits), .LineBits(LineBits),
    .FiltEntries(FiltEntries), .FifoDepth(FifoDepth)
  ) dut (
    .clk(clk), .reset(reset),
    .pred_addr(pred_addr), .pred_valid(pred_valid), .pred_retry(pred_retry),
    .pf_addr(pf_addr), .pf_valid(pf_valid), .pf_retry(pf_retry),
    .flush(flush)
`ifdef PFM_PRED_FILTER_STATS_EN
    , .stat_drop(stat_drop), .stat_issue(stat_issue), .stat_stall(stat_stall)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Scoreboard and reference model
  logic [AddrBits-1:0] exp_q [$];
  logic [AddrBits-1:0] issued_log [$];
  logic [AddrBits-1:0] exp_log [$];
  logic [TagW-1:0]     m_tag [FiltEntries];
  logic [FiltEntries-1:0] m_valid;
  int                  m_ptr;
  int                  m_drop, m_issue, m_stall;

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    exp_q.delete();
    m_valid = '0;
    m_ptr   = 0;
    m_drop  = 0;
    m_issue = 0;
    m_stall = 0;
  endtask

  // One clock cycle: called just after a negedge with inputs already driven.
  task automatic step(output bit acc_o);
    bit full, xfer, hit;
    logic [TagW-1:0] t;
    acc_o = 1'b0;
    #1;
    full = (exp_q.size() == FifoDepth);
    check_val("pred_retry", pred_retry, full);
    check_val("pf_valid", pf_valid, exp_q.size() != 0);
    if (exp_q.size() != 0) check_val("pf_addr", pf_addr, exp_q[0]);
`ifdef PFM_PRED_FILTER_STATS_EN
    check_val("stat_drop", stat_drop, m_drop);
    check_val("stat_issue", stat_issue, m_issue);
    check_val("stat_stall", stat_stall, m_stall);
`endif
    if (reset) begin
      model_clear();
    end else begin
      xfer = (exp_q.size() != 0) && !pf_retry;
      if (pred_valid && full) m_stall++;
      if (xfer) begin
        issued_log.push_back(pf_addr);
        $display("pf issue 0x%012h", exp_q[0]);
        void'(exp_q.pop_front());
        m_issue++;
      end
      if (pred_valid && !full) begin
        acc_o = 1'b1;
        t   = pred_addr[AddrBits-1:LineBits];
        hit = 1'b0;
        if (!flush) begin
          for (int i = 0; i < FiltEntries; i++)
            if (m_valid[i] && m_tag[i] == t) hit = 1'b1;
        end
        if (flush) begin
          m_valid = '0;
          m_ptr   = 0;
        end
        if (hit) begin
          m_drop++;
          $display("pred 0x%012h dropped", pred_addr);
        end else begin
          exp_q.push_back({t, {LineBits{1'b0}}});
          m_tag[m_ptr]   = t;
          m_valid[m_ptr] = 1'b1;
          m_ptr          = (m_ptr + 1) % FiltEntries;
          $display("pred 0x%012h queued", pred_addr);
        end
      end else if (flush) begin
        m_valid = '0;
        m_ptr   = 0;
      end
    end
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    bit a;
    pred_valid = 1'b0;
    pred_addr  = 'x;
    for (int i = 0; i < n; i++) step(a);
  endtask

  task automatic send(input logic [AddrBits-1:0] addr);
    bit acc = 1'b0;
    pred_valid = 1'b1;
    pred_addr  = addr;
    for (int i = 0; i < 20 && !acc; i++) step(acc);
    check_val("send_accept", acc, 1'b1);
    pred_valid = 1'b0;
    pred_addr  = 'x;
  endtask

  task automatic drain();
    bit a;
    pred_valid = 1'b0;
    pf_retry   = 1'b0;
    for (int i = 0; i < 40 && exp_q.size() != 0; i++) step(a);
    check_val("drain_empty", exp_q.size(), 0);
    step(a);
  endtask

  task automatic check_log(input string tag);
    check_val({tag, "_count"}, issued_log.size(), exp_log.size());
    for (int i = 0; i < exp_log.size() && i < issued_log.size(); i++)
      check_val(tag, issued_log[i], exp_log[i]);
    issued_log.delete();
  endtask

  initial begin
    bit a;
    reset      = 1'b1;
    pred_valid = 1'b0;
    pred_addr  = '0;
    pf_retry   = 1'b0;
    flush      = 1'b0;
    model_clear();
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    check_val("reset_pf_valid", pf_valid, 1'b0);
    check_val("reset_pf_addr", pf_addr, 48'h0);
    check_val("reset_pred_retry", pred_retry, 1'b0);

    // Single prediction, one-cycle latency to pf_valid
    send(48'h0000_1234_5678);
    #1;
    check_val("t1_pf_valid", pf_valid, 1'b1);
    check_val("t1_pf_addr", pf_addr, 48'h0000_1234_5640);
    check_val("t1_pred_retry", pred_retry, 1'b0);
    drain();
    exp_log = '{48'h0000_1234_5640};
    check_log("t1_log");

    // Same-line predictions back to back
    send(48'h1000);
    send(48'h1008);
    send(48'h1030);
    drain();
    exp_log = '{48'h1000};
    check_log("t2_log");
`ifdef PFM_PRED_FILTER_STATS_EN
    check_val("t2_stat_drop", stat_drop, 16'd2);
    check_val("t2_stat_issue", stat_issue, 16'd2);
`endif

    // Fill the FIFO under pf_retry, stall the fifth prediction
    pf_retry = 1'b1;
    send(48'h0);
    send(48'h40);
    send(48'h80);
    send(48'hC0);
    pred_valid = 1'b1;
    pred_addr  = 48'h100;
    for (int i = 0; i < 3; i++) step(a);
    #1;
    check_val("t3_pred_retry", pred_retry, 1'b1);
    check_val("t3_head_stable", pf_addr, 48'h0);
    pf_retry = 1'b0;
    send(48'h100);
    drain();
    exp_log = '{48'h0, 48'h40, 48'h80, 48'hC0, 48'h100};
    check_log("t3_log");

    // Round-robin replacement overwrites the oldest line
    flush = 1'b1;
    idle(1);
    flush = 1'b0;
    for (int i = 0; i < FiltEntries; i++) send(48'(i * 64));
    send(48'h1000);
    send(48'h40);
    send(48'h0);
    drain();
    exp_log = '{48'h0, 48'h40, 48'h80, 48'hC0, 48'h100, 48'h140, 48'h180,
                48'h1C0, 48'h1000, 48'h0};
    check_log("t4_log");

    // flush with a same-cycle prediction
    send(48'h2000);
    flush = 1'b1;
    send(48'h3000);
    flush = 1'b0;
    send(48'h2000);
    send(48'h3000);
    drain();
    exp_log = '{48'h2000, 48'h3000, 48'h2000};
    check_log("t5_log");

    // Reset with entries queued
    pf_retry = 1'b1;
    send(48'h4000);
    send(48'h4040);
    send(48'h4080);
    reset = 1'b1;
    idle(1);
    reset = 1'b0;
    #1;
    check_val("t6_pf_valid", pf_valid, 1'b0);
    check_val("t6_pred_retry", pred_retry, 1'b0);
    pf_retry = 1'b0;
    send(48'h4000);
    drain();
    exp_log = '{48'h4000};
    check_log("t6_log");

    // Randomised traffic with back-pressure and occasional flush
    a = 1'b1;
    for (int i = 0; i < 120; i++) begin
      if (a || !pred_valid) begin
        pred_valid = ($urandom_range(0, 3) != 0);
        pred_addr  = 48'($urandom_range(0, 4095));
      end
      pf_retry = ($urandom_range(0, 2) == 0);
      flush    = ($urandom_range(0, 15) == 0);
      step(a);
    end
    flush = 1'b0;
    drain();
    issued_log.delete();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
